// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, NOP encoding and fetch-stage types.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    IF_BOOT,
    IF_REQ,
    IF_HOLD
  } if_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc1;
  } skid_entry_t;

endpackage

// File: rtl/instr_skid_buf.sv
// One-entry holding register for a word acked while decode is stalled,
// paired with the PC+1 of the address it was fetched from.
module instr_skid_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load_i,
  input  logic        unload_i,
  input  skid_entry_t data_i,
  output skid_entry_t data_o,
  output logic        empty_o
);

  skid_entry_t data_q, data_d;
  logic        full_q, full_d;

  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (load_i) begin
      data_d = data_i;
      full_d = 1'b1;
    end else if (unload_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o  = data_q;
  assign empty_o = ~full_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage: owns PC, issues req/ack word reads and drives the IF/DE register
// plus the PC_2 copy used by execute for branch-target arithmetic.
module instr_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [WORD_W-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] PC_NEXT,
  input  logic              STALL,
  input  logic [WORD_W-1:0] IMEM_RDATA,
  input  logic              IMEM_ACK,
  output logic              IMEM_REQ,
  output logic [WORD_W-1:0] IMEM_ADDR,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] PC_1,
  output logic [WORD_W-1:0] IR,
  output logic              IR_VALID,
  output logic [WORD_W-1:0] PC_1_D,
  output logic [WORD_W-1:0] PC_2
);

  if_state_e         state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic [WORD_W-1:0] pc1_d_q, pc1_d_d;
  logic [WORD_W-1:0] pc2_q, pc2_d;
  logic [WORD_W-1:0] pc_plus1;
  logic              req;
  logic              skid_load, skid_unload, skid_empty;
  skid_entry_t       skid_in, skid_out;

  assign pc_plus1 = pc_q + 32'd1;
  assign skid_in  = '{instr: IMEM_RDATA, pc1: pc_plus1};

  instr_skid_buf u_skid (
    .clk      (clk),
    .reset    (reset),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (skid_in),
    .data_o   (skid_out),
    .empty_o  (skid_empty)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    pc1_d_d     = pc1_d_q;
    pc2_d       = pc2_q;
    req         = 1'b0;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    case (state_q)
      IF_BOOT: state_d = IF_REQ;
      IF_REQ: begin
        req = 1'b1;
        if (IMEM_ACK) begin
          pc_d = PC_NEXT;
          // A stalled decode cannot take the word, so park it rather than re-fetch.
          if (STALL) begin
            skid_load = 1'b1;
            state_d   = IF_HOLD;
          end else begin
            ir_d       = IMEM_RDATA;
            ir_valid_d = 1'b1;
            pc1_d_d    = pc_plus1;
            pc2_d      = pc1_d_q;
          end
        end else if (!STALL) begin
          ir_d       = NOP_INSTR;
          ir_valid_d = 1'b0;
          pc2_d      = pc1_d_q;
        end
      end
      IF_HOLD: begin
        if (!STALL && !skid_empty) begin
          ir_d        = skid_out.instr;
          ir_valid_d  = 1'b1;
          pc1_d_d     = skid_out.pc1;
          pc2_d       = pc1_d_q;
          skid_unload = 1'b1;
          state_d     = IF_REQ;
        end
      end
      default: state_d = IF_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IF_BOOT;
      pc_q       <= RESET_PC;
      ir_q       <= NOP_INSTR;
      ir_valid_q <= 1'b0;
      pc1_d_q    <= '0;
      pc2_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      pc1_d_q    <= pc1_d_d;
      pc2_q      <= pc2_d;
    end
  end

  assign IMEM_REQ  = req;
  assign IMEM_ADDR = pc_q;
  assign PC        = pc_q;
  assign PC_1      = pc_plus1;
  assign IR        = ir_q;
  assign IR_VALID  = ir_valid_q;
  assign PC_1_D    = pc1_d_q;
  assign PC_2      = pc2_q;

endmodule
